// File: rtl/cache_control_nway_if.sv
// Request, pmem, datapath-control and counter signals of the N-way cache controller.
// master = requester/datapath/memory side, slave = the controller itself.
interface cache_control_nway_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32
);
  localparam int WW = $clog2(WAYS);
  localparam int SW = $clog2(SETS);

  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic [SW-1:0]    set_idx;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  valid_vec;
  logic [WAYS-1:0]  dirty_vec;
  logic [WW-1:0]    way_sel;
  logic [WAYS-1:0]  load_data;
  logic [WAYS-1:0]  load_tag;
  logic [WAYS-1:0]  load_valid;
  logic [WAYS-1:0]  load_dirty;
  logic             dirty_in;
  logic             data_in_sel;
  logic             pmem_addr_sel;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;
  logic             count_clr;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp, count_clr,
    input  mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, dirty_in,
           data_in_sel, pmem_addr_sel, pmem_read, pmem_write, hit_count, miss_count, wb_count
  );

  modport slave (
    input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp, count_clr,
    output mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, dirty_in,
           data_in_sel, pmem_addr_sel, pmem_read, pmem_write, hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_control_nway.sv
// N-way write-back/write-allocate cache controller: tree-PLRU replacement,
// writeback-then-allocate miss handling, saturating hit/miss/writeback counters.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_control_nway_if.slave bus
);
  localparam int WW = $clog2(WAYS);
  localparam int SW = $clog2(SETS);
  localparam int NB = WAYS - 1;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t               state_q, state_d;
  logic [SETS-1:0][NB-1:0] plru_q;
  logic [WW-1:0]        victim_q;
  logic [SW-1:0]        set_q;
  logic                 replay_q;
  logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic [WW-1:0]   hit_way, victim, way_sel;
  logic [WAYS-1:0] load_data, load_tag, load_valid, load_dirty;
  logic            mem_resp, dirty_in, data_in_sel, pmem_addr_sel, pmem_read, pmem_write;
  logic            hit_now, miss_now, wb_done, replay_set, touch;
  logic [SW-1:0]   touch_set;
  logic [WW-1:0]   touch_way;

  // Walk the heap from the root; each node bit picks the half holding the victim.
  function automatic logic [WW-1:0] tree_victim(input logic [NB-1:0] t);
    int node;
    logic [WW-1:0] w;
    node = 0;
    w    = '0;
    for (int l = WW-1; l >= 0; l--) begin
      w[l] = t[node];
      node = 2*node + 1 + int'(t[node]);
    end
    return w;
  endfunction

  function automatic logic [NB-1:0] tree_touch(input logic [NB-1:0] t, input logic [WW-1:0] w);
    int node;
    logic [NB-1:0] r;
    node = 0;
    r    = t;
    for (int l = WW-1; l >= 0; l--) begin
      r[node] = ~w[l];
      node    = 2*node + 1 + int'(w[l]);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (bus.hit_vec[i]) hit_way = WW'(i);
  end

  // Invalid ways take precedence over the PLRU choice; lowest index wins.
  always_comb begin
    victim = tree_victim(plru_q[bus.set_idx]);
    for (int i = WAYS-1; i >= 0; i--)
      if (!bus.valid_vec[i]) victim = WW'(i);
  end

  always_comb begin
    state_d       = state_q;
    way_sel       = '0;
    load_data     = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    mem_resp      = 1'b0;
    dirty_in      = 1'b0;
    data_in_sel   = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    hit_now       = 1'b0;
    miss_now      = 1'b0;
    wb_done       = 1'b0;
    replay_set    = 1'b0;
    touch         = 1'b0;
    touch_set     = bus.set_idx;
    touch_way     = hit_way;
    // Outputs are forced low while reset is held, even with a request pending.
    if (rst_n) begin
      case (state_q)
        COMPARE: begin
          if (bus.mem_read || bus.mem_write) begin
            if (|bus.hit_vec) begin
              hit_now  = 1'b1;
              touch    = 1'b1;
              way_sel  = hit_way;
              mem_resp = 1'b1;
              if (bus.mem_write) begin
                load_data[hit_way]  = 1'b1;
                load_dirty[hit_way] = 1'b1;
                dirty_in            = 1'b1;
              end
            end else begin
              miss_now = 1'b1;
              state_d  = (bus.valid_vec[victim] && bus.dirty_vec[victim]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
          if (bus.pmem_resp) begin
            wb_done = 1'b1;
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          data_in_sel = 1'b1;
          way_sel     = victim_q;
          if (bus.pmem_resp) begin
            load_data[victim_q]  = 1'b1;
            load_tag[victim_q]   = 1'b1;
            load_valid[victim_q] = 1'b1;
            load_dirty[victim_q] = 1'b1;
            touch      = 1'b1;
            touch_set  = set_q;
            touch_way  = victim_q;
            replay_set = 1'b1;
            state_d    = COMPARE;
          end
        end
        default: state_d = COMPARE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COMPARE;
      plru_q   <= '0;
      victim_q <= '0;
      set_q    <= '0;
      replay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_now) begin
        victim_q <= victim;
        set_q    <= bus.set_idx;
      end
      if (touch) plru_q[touch_set] <= tree_touch(plru_q[touch_set], touch_way);
      if (replay_set)   replay_q <= 1'b1;
      else if (hit_now) replay_q <= 1'b0;
    end
  end

  // The replayed hit after a fill belongs to the miss, not to the hit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (bus.count_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= bump(hit_cnt_q, hit_now && !replay_q);
      miss_cnt_q <= bump(miss_cnt_q, miss_now);
      wb_cnt_q   <= bump(wb_cnt_q, wb_done);
    end
  end

  assign bus.way_sel       = way_sel;
  assign bus.load_data     = load_data;
  assign bus.load_tag      = load_tag;
  assign bus.load_valid    = load_valid;
  assign bus.load_dirty    = load_dirty;
  assign bus.mem_resp      = mem_resp;
  assign bus.dirty_in      = dirty_in;
  assign bus.data_in_sel   = data_in_sel;
  assign bus.pmem_addr_sel = pmem_addr_sel;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.hit_count     = hit_cnt_q;
  assign bus.miss_count    = miss_cnt_q;
  assign bus.wb_count      = wb_cnt_q;
endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4, SETS=8, CNT_W=4): per-cycle vector
// table for fill/PLRU/writeback flow, plus counter and reset sequences.
module tb_cache_control_nway;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cache_control_nway_if #(.WAYS(4), .SETS(8), .CNT_W(4)) bus ();
  cache_control_nway #(.WAYS(4), .SETS(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && (bus.mem_read || bus.mem_write))
      assert ($onehot0(bus.hit_vec)) else $error("multiple hit_vec bits set: %b", bus.hit_vec);

  typedef struct {
    logic       rd, wr, presp;
    logic [3:0] hit, vld, drt;
    logic       resp;
    logic [1:0] way;
    logic [3:0] ldd, ldf, ldy;
    logic       di, ds, as, pr, pw;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int rd, wr, hit, vld, drt, presp,
                              input int resp, way, ldd, ldf, ldy, di, ds, as, pr, pw);
    vec_t v;
    v.rd = 1'(rd);  v.wr = 1'(wr);  v.hit = 4'(hit); v.vld = 4'(vld); v.drt = 4'(drt);
    v.presp = 1'(presp); v.resp = 1'(resp); v.way = 2'(way);
    v.ldd = 4'(ldd); v.ldf = 4'(ldf); v.ldy = 4'(ldy);
    v.di = 1'(di); v.ds = 1'(ds); v.as = 1'(as); v.pr = 1'(pr); v.pw = 1'(pw);
    vq.push_back(v);
  endfunction

  function automatic logic [31:0] outs();
    return {8'b0, bus.mem_resp, bus.way_sel, bus.load_data, bus.load_tag, bus.load_valid,
            bus.load_dirty, bus.dirty_in, bus.data_in_sel, bus.pmem_addr_sel,
            bus.pmem_read, bus.pmem_write};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, leave sampling to the caller.
  task automatic cyc(input int rd, wr, hit, vld, drt, presp, clr);
    @(negedge clk);
    bus.mem_read  = 1'(rd);
    bus.mem_write = 1'(wr);
    bus.hit_vec   = 4'(hit);
    bus.valid_vec = 4'(vld);
    bus.dirty_vec = 4'(drt);
    bus.pmem_resp = 1'(presp);
    bus.count_clr = 1'(clr);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(vq[i].rd, vq[i].wr, vq[i].hit, vq[i].vld, vq[i].drt, vq[i].presp, 0);
      check($sformatf("vec%0d", i), outs(),
            {8'b0, vq[i].resp, vq[i].way, vq[i].ldd, vq[i].ldf, vq[i].ldf, vq[i].ldy,
             vq[i].di, vq[i].ds, vq[i].as, vq[i].pr, vq[i].pw});
    end
  endtask

  task automatic cnt_check(input string name, input int h, m, w);
    @(posedge clk);
    #1;
    check({name, "_hit"},  32'(bus.hit_count),  32'(h));
    check({name, "_miss"}, 32'(bus.miss_count), 32'(m));
    check({name, "_wb"},   32'(bus.wb_count),   32'(w));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //  rd wr hit vld drt pr | rs way ldd ldf ldy di ds as pr pw
    // cold fill of set 3: ways 0..3 in order, each followed by its replay hit
    add(1,0,'h0,'h0,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h0,0,0,  0,0,'h0,'h0,'h0,0,1,0,1,0);
    add(1,0,'h0,'h0,0,1,  0,0,'h1,'h1,'h1,0,1,0,1,0);
    add(1,0,'h1,'h1,0,0,  1,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h1,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h1,0,1,  0,1,'h2,'h2,'h2,0,1,0,1,0);
    add(1,0,'h2,'h3,0,0,  1,1,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h3,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h3,0,1,  0,2,'h4,'h4,'h4,0,1,0,1,0);
    add(1,0,'h4,'h7,0,0,  1,2,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h7,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'h7,0,1,  0,3,'h8,'h8,'h8,0,1,0,1,0);
    add(1,0,'h8,'hF,0,0,  1,3,'h0,'h0,'h0,0,0,0,0,0);
    // full set: PLRU victim is way 0
    add(1,0,'h0,'hF,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'hF,0,1,  0,0,'h1,'h1,'h1,0,1,0,1,0);
    add(1,0,'h1,'hF,0,0,  1,0,'h0,'h0,'h0,0,0,0,0,0);
    // read-hit 0, write-hit 2, hit 3, hit 0 -> victim way 2 (dirty)
    add(1,0,'h1,'hF,0,0,  1,0,'h0,'h0,'h0,0,0,0,0,0);
    add(0,1,'h4,'hF,0,0,  1,2,'h4,'h0,'h4,1,0,0,0,0);
    add(1,0,'h8,'hF,4,0,  1,3,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h1,'hF,4,0,  1,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'hF,4,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(1,0,'h0,'hF,4,0,  0,2,'h0,'h0,'h0,0,0,1,0,1);
    add(1,0,'h0,'hF,4,0,  0,2,'h0,'h0,'h0,0,0,1,0,1);
    add(1,0,'h0,'hF,4,1,  0,2,'h0,'h0,'h0,0,0,1,0,1);
    add(1,0,'h0,'hF,4,0,  0,2,'h0,'h0,'h0,0,1,0,1,0);
    add(1,0,'h0,'hF,4,1,  0,2,'h4,'h4,'h4,0,1,0,1,0);
    add(1,0,'h4,'hF,0,0,  1,2,'h0,'h0,'h0,0,0,0,0,0);
    // idle: stray pmem_resp in COMPARE does nothing
    add(0,0,'h0,'hF,0,1,  0,0,'h0,'h0,'h0,0,0,0,0,0);
    add(0,0,'h0,'hF,0,0,  0,0,'h0,'h0,'h0,0,0,0,0,0);

    bus.set_idx = 3'd3;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.hit_vec = 4'h1; bus.valid_vec = 4'h1;
    bus.dirty_vec = 4'h0; bus.pmem_resp = 1'b0; bus.count_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset_outs", outs(), 32'h0);
    check("reset_cnts", {20'b0, bus.hit_count, bus.miss_count, bus.wb_count}, 32'h0);
    cyc(0,0,0,0,0,0,0);
    rst_n = 1'b1;

    run_vecs(0, 12);
    cnt_check("cold", 0, 4, 0);
    run_vecs(13, 28);
    cnt_check("flow", 4, 6, 1);

    for (int i = 0; i < 20; i++) cyc(1,0,'h1,'hF,0,0,0);
    @(posedge clk); #1;
    check("sat_hit", 32'(bus.hit_count), 32'd15);
    cyc(1,0,'h1,'hF,0,0,1);
    cnt_check("clr", 0, 0, 0);
    cyc(1,0,'h1,'hF,0,0,0);
    cnt_check("post_clr", 1, 0, 0);

    // PLRU now picks way 3; reset mid-fill must clear it back to way 0
    cyc(1,0,'h0,'hF,0,0,0);
    cyc(1,0,'h0,'hF,0,0,0);
    check("alloc_pre_rst", 32'({bus.way_sel, bus.pmem_read}), 32'({2'd3, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("alloc_rst_outs", outs(), 32'h0);
    check("alloc_rst_cnts", {20'b0, bus.hit_count, bus.miss_count, bus.wb_count}, 32'h0);
    cyc(0,0,0,'hF,0,0,0);
    rst_n = 1'b1;
    cyc(1,0,'h0,'hF,0,0,0);
    cyc(1,0,'h0,'hF,0,1,0);
    check("rst_refill", outs(), {8'b0, 1'b0, 2'd0, 4'h1, 4'h1, 4'h1, 4'h1, 5'b01010});
    cyc(1,0,'h1,'hF,0,0,0);
    check("rst_replay", outs(), {8'b0, 1'b1, 2'd0, 16'h0, 5'b00000});
    cyc(0,0,0,'hF,0,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Parametrised successor to the 2-way L2 cache controller.
- Controls an N-way set-associative, write-back, write-allocate cache. It selects the hit way, holds per-set tree pseudo-LRU state internally, prefers invalid ways as victims, and runs writeback then allocate.
- Exposes saturating hit/miss/writeback performance counters.
- Sits between the requesting level (CPU or L1) and physical memory. The tag/data arrays live in a separate datapath.

Parameters:
- WAYS, 4, associativity; power of two, at least 2. WAYS=2 reduces to a single LRU bit.
- SETS, 8, number of sets; power of two. Sizes the internal PLRU array.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse
- set_idx  in  log2(SETS)  set index of the current request
- hit_vec  in  WAYS  per-way tag match AND valid, from datapath
- valid_vec  in  WAYS  valid bits of the addressed set
- dirty_vec  in  WAYS  dirty bits of the addressed set
- way_sel  out  log2(WAYS)  way steering the datapath read/write muxes
- load_data  out  WAYS  per-way data array write enable
- load_tag  out  WAYS  per-way tag array write enable
- load_valid  out  WAYS  per-way valid write enable; written value is 1
- load_dirty  out  WAYS  per-way dirty write enable
- dirty_in  out  1  value written to the dirty bit
- data_in_sel  out  1  data array source: 0 = CPU write data, 1 = pmem line
- pmem_addr_sel  out  1  pmem address: 0 = request tag, 1 = victim tag
- pmem_read  out  1  pmem line read, held until pmem_resp
- pmem_write  out  1  pmem line write, held until pmem_resp
- pmem_resp  in  1  pmem completion pulse
- count_clr  in  1  synchronous clear of all counters
- hit_count  out  CNT_W  first-pass hits
- miss_count  out  CNT_W  misses
- wb_count  out  CNT_W  dirty writebacks

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = COMPARE; all PLRU bits = 0; victim_q = 0; replay_q = 0; counters = 0.
  - All outputs 0, including way_sel.
  - Reset during WRITEBACK or ALLOCATE abandons the pmem transaction; pmem_read and pmem_write drop immediately.
- Defaults in every state: all load_* = 0, dirty_in = 0, data_in_sel = 0, pmem_addr_sel = 0, mem_resp = 0.
- PLRU:
  - WAYS-1 bits per set, heap-indexed: root node 0; children of node i are 2i+1 and 2i+2.
  - Node bit 0 means the victim lies in the lower-index half.
  - On access to way w, every node on w's path is set to point away from w.
  - Victim = lowest-index invalid way if any valid_vec bit is 0; otherwise follow the node bits from the root.
- COMPARE, request = mem_read OR mem_write:
  - Hit (hit_vec nonzero): way_sel = index of the hit bit. mem_resp = 1 in the same cycle. PLRU[set_idx] updated at the clock edge.
  - Write hit: additionally load_data[w] = 1, load_dirty[w] = 1, dirty_in = 1, data_in_sel = 0.
  - hit_count increments only when replay_q = 0. replay_q clears on any hit.
  - More than one bit set in hit_vec is illegal; the bench asserts on it.
  - Miss: latch the victim into victim_q; miss_count += 1. Next state is WRITEBACK if valid_vec[victim] AND dirty_vec[victim], else ALLOCATE.
  - No request: stay in COMPARE. pmem_resp is ignored in COMPARE.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = victim_q.
  - On pmem_resp: wb_count += 1, go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1, pmem_addr_sel = 0, data_in_sel = 1, way_sel = victim_q.
  - On pmem_resp: load_data, load_tag, load_valid and load_dirty for victim_q = 1; dirty_in = 0.
  - In the same cycle: PLRU is touched for victim_q, replay_q is set, and the FSM returns to COMPARE.
  - The request then hits in the next cycle and completes as a normal hit (write data merged, dirty set), without counting as a hit.
- A request withdrawn mid-miss does not abort the fill; the fill always completes.
- Counters saturate at 2^CNT_W-1. count_clr has priority over a same-cycle increment.
- Miss latency = pmem cycles + 2 clocks from request to mem_resp (clean victim).

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously, counters 0, state COMPARE.
- Cold fill, set 3, WAYS=4: four reads to distinct tags -> ways 0,1,2,3 allocated in order, no pmem_write, miss_count=4, hit_count=0, each mem_resp one cycle after the fill's pmem_resp.
- PLRU: after the fills, miss to set 3 -> victim way 0. Instead read-hit way 0 first, then miss -> victim way 2.
- Dirty eviction: write-hit way 2 (load_data=4'b0100, dirty_in=1, mem_resp same cycle), then a miss whose victim is way 2 -> pmem_write with pmem_addr_sel=1 held 3 cycles until pmem_resp, wb_count=1, then ALLOCATE.
- Counters, CNT_W=4: 20 hits -> hit_count=15. count_clr concurrent with a hit -> hit_count=0 next cycle.
- Reset asserted during ALLOCATE -> pmem_read falls immediately, PLRU cleared, the next request to the set misses into way 0.
